// File: rtl/keypad_matrix_scan_pkg.sv
// keypad_pkg: shared constants, column-state encoding and small helpers for
// the 3x4 matrix keypad scanner.
//   NUM_ROWS / NUM_COLS / NUM_KEYS : matrix geometry (key index = row*3 + col)
//   KEY_NONE  : code reported when no key is stable
//   KEY_MULTI : internal frame result when two or more keys are seen
//   col_state_t : column FSM states
//   frame_result() : 12-bit frame vector -> NONE / key index / MULTI
//   key_onehot()   : key code -> 12-bit one-hot (zero for non-key codes)
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_MULTI = 4'hE;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } col_state_t;

  function automatic logic [3:0] frame_result(input logic [NUM_KEYS-1:0] vec);
    logic [3:0] code;
    int         hits;
    code = KEY_NONE;
    hits = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (vec[i]) begin
        hits = hits + 1;
        code = 4'(i);
      end
    end
    if (hits > 1) code = KEY_MULTI;
    return code;
  endfunction

  function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [3:0] code);
    logic [NUM_KEYS-1:0] v;
    for (int i = 0; i < NUM_KEYS; i++) v[i] = (code == 4'(i));
    return v;
  endfunction

endpackage

// File: rtl/keypad_matrix_scan_if.sv
// keypad_matrix_scan_if: pin-side and game-side signals of the keypad scanner.
//   row_in     : matrix row lines, active-high, asynchronous
//   col_out    : one-hot column drive, active-high
//   key_code   : stable key index 0..11, or KEY_NONE
//   key_valid  : one-cycle pulse on each new stable key
//   key_held   : high while a stable key is present
//   keypad_out : one-hot of the stable key, zero when none
// master = scanner side, slave = keypad/game side.
interface keypad_matrix_scan_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_in;
  logic [NUM_COLS-1:0] col_out;
  logic [3:0]          key_code;
  logic                key_valid;
  logic                key_held;
  logic [NUM_KEYS-1:0] keypad_out;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_held, keypad_out
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_held, keypad_out
  );

endinterface

// File: rtl/keypad_matrix_scan_debounce.sv
// key_debounce: frame-level debouncer for the keypad scanner.
//   clk, rst    : clock, synchronous active-high reset
//   frame_code  : result of the frame just completed (NONE / index / MULTI)
//   frame_stb   : high for the one cycle frame_code is valid
//   stable_code : stable value including this frame's decision
//   update_stb  : high in the frame_stb cycle when the stable value changes
// A result must repeat DEBOUNCE frames in a row to become stable. MULTI is
// counted like any other result but is never adopted.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] frame_code,
  input  logic       frame_stb,
  output logic [3:0] stable_code,
  output logic       update_stb
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [3:0]       prev_code;
  logic [3:0]       stable_q;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] match_next;

  always_comb begin
    match_next  = match_cnt;
    update_stb  = 1'b0;
    stable_code = stable_q;
    if (frame_stb) begin
      if (frame_code == prev_code) begin
        // saturate so a long-held result keeps qualifying
        if (match_cnt != CNT_W'(DEBOUNCE)) match_next = match_cnt + CNT_W'(1);
      end else begin
        match_next = CNT_W'(1);
      end
      if ((match_next == CNT_W'(DEBOUNCE)) && (frame_code != stable_q) &&
          (frame_code != KEY_MULTI)) begin
        update_stb  = 1'b1;
        stable_code = frame_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_code <= KEY_NONE;
      match_cnt <= '0;
      stable_q  <= KEY_NONE;
    end else if (frame_stb) begin
      prev_code <= frame_code;
      match_cnt <= match_next;
      if (update_stb) stable_q <= frame_code;
    end
  end

endmodule

// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: active 3x4 matrix keypad scanner.
//   clk, rst : clock, synchronous active-high reset
//   kp       : keypad_matrix_scan_if.master (row_in, col_out, key_code,
//              key_valid, key_held, keypad_out)
// Drives one column for SCAN_DIV cycles at a time, captures the synchronized
// rows on the last dwell cycle, builds a 12-bit frame every 3 columns and
// hands the frame result to key_debounce. Outputs are registered and change
// the cycle after the deciding frame end.
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_matrix_scan_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [NUM_ROWS-1:0] row_p0;
  logic [NUM_ROWS-1:0] row_p1;
  col_state_t          state;
  col_state_t          state_next;
  logic [DIV_W-1:0]    dwell_cnt;
  logic                dwell_last;
  logic                frame_stb;
  logic [NUM_COLS-1:0] col_drive;
  logic [NUM_KEYS-1:0] frame_vec;
  logic [NUM_KEYS-1:0] capture_bits;
  logic [NUM_KEYS-1:0] frame_full;
  logic [3:0]          frame_code;
  logic [3:0]          stable_code;
  logic                update_stb;
  logic [3:0]          key_code_q;
  logic                key_valid_q;
  logic                key_held_q;
  logic [NUM_KEYS-1:0] keypad_out_q;

  // ---- stage p0/p1: two-flop synchronizer for the asynchronous rows ----
  always_ff @(posedge clk) begin
    row_p0 <= kp.row_in;
    row_p1 <= row_p0;
  end

  // ---- column FSM and dwell counter ----
  assign dwell_last = (dwell_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_stb  = dwell_last && (state == COL2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COL0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_next;
      dwell_cnt <= dwell_last ? '0 : dwell_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    col_drive  = 3'b001;
    case (state)
      COL0: begin
        col_drive = 3'b001;
        if (dwell_last) state_next = COL1;
      end
      COL1: begin
        col_drive = 3'b010;
        if (dwell_last) state_next = COL2;
      end
      COL2: begin
        col_drive = 3'b100;
        if (dwell_last) state_next = COL0;
      end
      default: begin
        col_drive  = 3'b001;
        state_next = COL0;
      end
    endcase
  end

  assign kp.col_out = col_drive;

  // ---- frame accumulator ----
  // The frame result includes the column being captured this cycle, so the
  // COL2 capture is folded in combinationally at frame end.
  always_comb begin
    capture_bits = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (col_drive[c]) capture_bits[r*NUM_COLS + c] = row_p1[r];
      end
    end
  end

  assign frame_full = frame_vec | capture_bits;
  assign frame_code = frame_result(frame_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_vec <= '0;
    end else if (dwell_last) begin
      frame_vec <= (state == COL2) ? '0 : frame_full;
    end
  end

  // ---- debounce ----
  key_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .frame_code  (frame_code),
    .frame_stb   (frame_stb),
    .stable_code (stable_code),
    .update_stb  (update_stb)
  );

  // ---- output registers ----
  // A change to NONE updates the level outputs but never pulses key_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_q   <= KEY_NONE;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      keypad_out_q <= '0;
    end else begin
      key_valid_q <= update_stb && (stable_code != KEY_NONE);
      if (update_stb) begin
        key_code_q   <= stable_code;
        key_held_q   <= (stable_code != KEY_NONE);
        keypad_out_q <= key_onehot(stable_code);
      end
    end
  end

  assign kp.key_code   = key_code_q;
  assign kp.key_valid  = key_valid_q;
  assign kp.key_held   = key_held_q;
  assign kp.keypad_out = keypad_out_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan: self-checking bench for keypad_matrix_scan with
// SCAN_DIV=8, DEBOUNCE=3 (24-cycle frame). The bench models the matrix:
// row r is high when a pressed key (r,c) sits on the driven column c.
module tb_keypad_matrix_scan;

  localparam int FRAME = 24;

  typedef struct packed {
    logic [11:0] press;
    int          frames;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;
    logic [11:0] exp_onehot;
    int          max_lat;
    bit          keep_held;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [11:0] pressed;
  logic [3:0]  rows;

  int checks;
  int failures;
  int pulses;
  int held_low;
  int consec;
  int cyc;
  int first_pulse;
  int k;
  bit prev_valid;

  vec_t vecs [0:7];

  keypad_matrix_scan_if kp ();

  keypad_matrix_scan #(
    .SCAN_DIV (8),
    .DEBOUNCE (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rows = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3 + c] && kp.col_out[c]) rows[r] = 1'b1;
      end
    end
  end
  assign kp.row_in = rows;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc = cyc + 1;
    if (kp.key_valid === 1'b1) begin
      pulses = pulses + 1;
      if (prev_valid) consec = consec + 1;
      if (first_pulse < 0) first_pulse = cyc;
    end
    prev_valid = (kp.key_valid === 1'b1);
    if (kp.key_held !== 1'b1) held_low = held_low + 1;
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) step();
  endtask

  task automatic clear_counts();
    pulses      = 0;
    held_low    = 0;
    cyc         = 0;
    first_pulse = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    consec     = 0;
    prev_valid = 1'b0;
    clear_counts();

    // press, frames, pulses, code, held, one-hot, max latency, held throughout
    vecs[0] = '{12'h020, 10, 1, 4'h5, 1'b1, 12'h020, 96, 1'b0}; // key 5
    vecs[1] = '{12'h000,  4, 0, 4'hF, 1'b0, 12'h000,  0, 1'b0}; // release
    vecs[2] = '{12'h011,  6, 0, 4'hF, 1'b0, 12'h000,  0, 1'b0}; // keys 0+4
    vecs[3] = '{12'h001,  4, 1, 4'h0, 1'b1, 12'h001,  0, 1'b0}; // drop 4
    vecs[4] = '{12'h000,  4, 0, 4'hF, 1'b0, 12'h000,  0, 1'b0};
    vecs[5] = '{12'h008,  4, 1, 4'h3, 1'b1, 12'h008,  0, 1'b0}; // key 3
    vecs[6] = '{12'h080,  4, 1, 4'h7, 1'b1, 12'h080,  0, 1'b1}; // 3 -> 7
    vecs[7] = '{12'h000,  4, 0, 4'hF, 1'b0, 12'h000,  0, 1'b0};

    // reset held for 3 edges
    rst     = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_col_out", 32'(kp.col_out), 32'h1);
    check("rst_key_code", 32'(kp.key_code), 32'hF);
    check("rst_keypad_out", 32'(kp.keypad_out), 32'h0);
    check("rst_key_valid", 32'(kp.key_valid), 32'h0);
    check("rst_key_held", 32'(kp.key_held), 32'h0);
    rst = 1'b0;

    // column rotation: 001 -> 010 -> 100 -> 001 every 8 cycles
    for (int n = 1; n <= FRAME; n++) begin
      step();
      if (n == 8)  check("col_at_8", 32'(kp.col_out), 32'h2);
      if (n == 16) check("col_at_16", 32'(kp.col_out), 32'h4);
      if (n == 24) check("col_at_24", 32'(kp.col_out), 32'h1);
    end

    // table-driven scenarios, each starting at a frame boundary
    for (int i = 0; i < 8; i++) begin
      pressed = vecs[i].press;
      clear_counts();
      run_frames(vecs[i].frames);
      check($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
      check($sformatf("v%0d_key_code", i), 32'(kp.key_code), 32'(vecs[i].exp_code));
      check($sformatf("v%0d_key_held", i), 32'(kp.key_held), 32'(vecs[i].exp_held));
      check($sformatf("v%0d_keypad_out", i), 32'(kp.keypad_out), 32'(vecs[i].exp_onehot));
      if (vecs[i].max_lat > 0)
        check($sformatf("v%0d_latency_ok", i),
              32'((first_pulse > 0) && (first_pulse <= vecs[i].max_lat)), 32'h1);
      if (vecs[i].keep_held)
        check($sformatf("v%0d_held_drops", i), 32'(held_low), 32'h0);
    end

    // bounce on key 9: toggle every 5 cycles for 2 frames, then hold
    clear_counts();
    for (int i = 0; i < 2 * FRAME; i++) begin
      pressed = (((i / 5) % 2) == 0) ? 12'h200 : 12'h000;
      step();
    end
    pressed = 12'h200;
    run_frames(4);
    check("bounce_pulses", 32'(pulses), 32'h1);
    check("bounce_key_code", 32'(kp.key_code), 32'h9);
    check("bounce_keypad_out", 32'(kp.keypad_out), 32'h200);
    pressed = '0;
    run_frames(4);
    check("bounce_release_code", 32'(kp.key_code), 32'hF);

    // reset while key 11 is held and stable
    pressed = 12'h800;
    clear_counts();
    run_frames(4);
    check("k11_pulses", 32'(pulses), 32'h1);
    check("k11_key_code", 32'(kp.key_code), 32'hB);
    repeat (5) step();
    rst = 1'b1;
    step();
    check("mid_rst_key_code", 32'(kp.key_code), 32'hF);
    check("mid_rst_key_held", 32'(kp.key_held), 32'h0);
    check("mid_rst_keypad_out", 32'(kp.keypad_out), 32'h0);
    check("mid_rst_key_valid", 32'(kp.key_valid), 32'h0);
    check("mid_rst_col_out", 32'(kp.col_out), 32'h1);
    rst = 1'b0;
    // first frame after reset ends at the 24th edge; third at the 72nd
    k = 0;
    while ((kp.key_valid !== 1'b1) && (k < 200)) begin
      step();
      k = k + 1;
    end
    check("post_rst_pulse_cycle", 32'(k), 32'd72);
    check("post_rst_key_code", 32'(kp.key_code), 32'hB);
    check("post_rst_keypad_out", 32'(kp.keypad_out), 32'h800);

    check("valid_consecutive", 32'(consec), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scan.md
# keypad_matrix_scan

Active scanner for the 3x4 matrix keypad. It drives one column at a time, samples the four row lines, and debounces the per-frame result. It emits a one-cycle `key_valid` pulse with a 4-bit key code for each new stable press, plus a level-held one-hot `keypad_out[11:0]` in the same format the existing keypad decode path consumes. It sits between the keypad pins and the game logic, replacing the passive 12-line keypad input.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column is driven. Minimum 4.
- `DEBOUNCE`, 4: consecutive identical frame results required before the result becomes stable. Minimum 1.
- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `row_in` in 4: matrix row lines, active-high (external pull-downs), asynchronous to `clk`.
- `col_out` out 3: one-hot column drive, active-high.
- `key_code` out 4: stable key index 0..11, or `KEY_NONE` = 4'hF when no key is stable.
- `key_valid` out 1: one-cycle pulse when a new stable key appears.
- `key_held` out 1: high while a stable key is present.
- `keypad_out` out 12: one-hot of the stable key (bit = `key_code`); all zero when none.

## Operation
- Key index = row*3 + col, with row 0..3 and col 0..2.
- `row_in` passes through a 2-flop synchronizer before any use.
- Column FSM states: COL0, COL1, COL2, cycling COL0→COL1→COL2→COL0.
  - Each state lasts `SCAN_DIV` cycles.
  - `col_out` = 3'b001 / 3'b010 / 3'b100 respectively.
- Sampling:
  - The synchronized rows are captured on the last cycle of each column dwell.
  - Captures accumulate into a 12-bit frame vector.
- Frame end (last cycle of COL2): the frame result is computed from the frame vector.
  - Zero bits set → NONE.
  - Exactly one bit set → that index.
  - Two or more bits set → MULTI.
  - The frame vector then clears.
- Debounce:
  - Compare the frame result with the previous frame result.
  - If equal, the match counter saturates at `DEBOUNCE`; otherwise it resets to 1.
  - When the counter reaches `DEBOUNCE` and the result differs from the current stable value, the stable value updates.
  - MULTI never becomes stable: the stable value is held and no pulse is generated.
- Output rules on a stable-value update:
  - NONE → key k: `key_code`=k, `key_held`=1, `keypad_out`=1<<k, `key_valid` pulses.
  - Key j → key k with no release in between: same as above, including a new pulse.
  - Key → NONE: `key_code`=4'hF, `key_held`=0, `keypad_out`=0, no pulse.
- `key_valid` is never high on two consecutive cycles.

## Timing
- Reset values: `col_out`=3'b001, `key_code`=4'hF, `key_valid`=0, `key_held`=0, `keypad_out`=0. The FSM, dwell counter, frame vector, previous result (NONE), and match counter are all cleared.
- Reset takes effect on the first `clk` edge with `rst`=1. Reset mid-dwell or mid-hold abandons the frame and debounce history.
- Frame period = 3*`SCAN_DIV` cycles.
- Dwell counter runs 0..`SCAN_DIV`-1, then wraps and the column advances.
- Row settling: a row change becomes visible 2 cycles after it appears at `row_in` (synchronizer depth). Changes within the last 2 cycles of a dwell are missed for that frame.
- Outputs are registered. `key_valid`, `key_code`, `key_held`, and `keypad_out` all change on the cycle after the deciding frame end.
- Press-to-pulse latency, for a clean press stable from the start of a frame: `DEBOUNCE` frames + 1 cycle. Worst case: (`DEBOUNCE`+1) frames + 1 cycle.

## Structure
- Package `keypad_pkg`:
  - Constants `NUM_ROWS`=4, `NUM_COLS`=3, `KEY_NONE`=4'hF, `KEY_MULTI`=4'hE (internal result code).
  - Column-state encoding.
- Sub-module `key_debounce`:
  - Inputs: frame result code and frame strobe.
  - Outputs: stable code and update strobe.
  - Contains the previous-result register and the match counter.
- Top-level `keypad_matrix_scan` contains the synchronizer, column FSM, dwell counter, frame accumulator, and output registers.

## Test plan
All scenarios use `SCAN_DIV`=8 and `DEBOUNCE`=3, giving a 24-cycle frame. The bench models the matrix: `row_in[r]` = `col_out[c]` when key (r,c) is pressed.
- Reset: hold `rst` 3 cycles → `col_out`=001, `key_code`=F, `keypad_out`=0, `key_valid`=0. `col_out` then advances every 8 cycles: 001, 010, 100, 001.
- Single press of key 5 (row 1, col 2), held 10 frames:
  - Exactly one `key_valid` pulse, within 96 cycles of the press.
  - `key_code`=5 and `keypad_out`=12'h020 while held.
  - On release, `key_held` drops within 4 frames with no pulse, and `key_code` returns to F.
- Bounce: key 9 toggled every 5 cycles for 2 frames, then held → exactly one pulse, `key_code`=9.
- Simultaneous keys 0 and 4 held 6 frames → no pulse, `key_code` stays F. Releasing key 4 then yields one pulse with `key_code`=0.
- Key change: key 3 held and stable, then switched to 7 with no gap → second pulse with `key_code`=7, and `key_held` stays 1 throughout.
- Reset while key 11 is held and stable → all outputs return to reset values next cycle. With the key still held, a new pulse with `key_code`=11 arrives 3 frames after reset release.
